// File: rtl/mdu_iter_if.sv
// Request/response bundle between decode/execute and the iterative RV64M unit.
// Strict valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// a master keeps valid and its payload steady until that edge, and ready never waits on valid.
interface mdu_iter_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, word, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, word, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one step per cycle.
// Build option MDU_FAST_PATH_EN: divide-by-zero, signed overflow and zero-operand multiply skip to DONE.
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  mdu_iter_if.slave        bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;

`ifdef MDU_FAST_PATH_EN
  localparam bit FastPath = 1'b1;
`else
  localparam bit FastPath = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [6:0]      cnt_q;
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;
  logic            rneg_q;
  logic            spec_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  // Operand preparation, magnitudes and special-case detection on the request inputs
  logic            s1_sgn, s2_sgn, is_div, neg1, neg2;
  logic            div0, ovf, mzero, special;
  logic [XLEN-1:0] p1, p2, m1, m2, min_val, spec_res;

  always_comb begin
    is_div  = bus.op[2];
    s1_sgn  = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    s2_sgn  = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    p1      = bus.src1;
    p2      = bus.src2;
    if (bus.word) begin
      if (is_div && !bus.op[0]) begin
        p1 = sext32(bus.src1);
        p2 = sext32(bus.src2);
      end else begin
        p1 = {{(XLEN-32){1'b0}}, bus.src1[31:0]};
        p2 = {{(XLEN-32){1'b0}}, bus.src2[31:0]};
      end
    end
    neg1    = s1_sgn && p1[XLEN-1];
    neg2    = s2_sgn && p2[XLEN-1];
    m1      = neg1 ? -p1 : p1;
    m2      = neg2 ? -p2 : p2;
    min_val = bus.word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = is_div && (p2 == '0);
    ovf     = is_div && !bus.op[0] && (p1 == min_val) && (p2 == '1);
    mzero   = !is_div && ((p1 == '0) || (p2 == '0));
    special = div0 || ovf || mzero;
    spec_res = '0;
    if (div0)     spec_res = bus.op[1] ? p1 : '1;
    else if (ovf) spec_res = bus.op[1] ? '0 : p1;
    if (bus.word) spec_res = sext32(spec_res);
  end

  // One iteration step
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[XLEN-1:0] - b_q;
  end

  // Sign correction and result selection; word products sit in bits [95:32] after 32 steps
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   quo, rem, sel_res, fin_res;

  always_comb begin
    prod_raw = word_q ? {{XLEN{1'b0}}, hi_q[31:0], lo_q[XLEN-1:32]} : {hi_q, lo_q};
    prod     = neg_q ? -prod_raw : prod_raw;
    quo      = neg_q ? -lo_q : lo_q;
    rem      = rneg_q ? -hi_q : hi_q;
    if (op_q[2])              sel_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == '0) sel_res = prod[XLEN-1:0];
    else                      sel_res = prod[2*XLEN-1:XLEN];
    fin_res  = word_q ? sext32(sel_res) : sel_res;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) state_d = (FastPath && special) ? DONE : CALC;
        CALC: if (cnt_q == 7'd1) state_d = POST;
        POST: state_d = DONE;
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = result_q;
    dbg_state_o   = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid && !bus.flush) begin
          op_q   <= bus.op;
          word_q <= bus.word;
          neg_q  <= neg1 ^ neg2;
          rneg_q <= neg1;
          spec_q <= special;
          cnt_q  <= bus.word ? 7'd32 : 7'd64;
          hi_q   <= '0;
          b_q    <= m2;
          // Word dividends start in the top half so 32 steps consume all their bits
          lo_q   <= (is_div && bus.word) ? {m1[31:0], {(XLEN-32){1'b0}}} : m1;
          if (special) result_q <= spec_res;
        end
        CALC: begin
          cnt_q <= cnt_q - 7'd1;
          if (op_q[2]) begin
            hi_q <= div_ge ? div_diff : div_sh[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        POST: if (!spec_q) result_q <= fin_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV64M vectors, latency, flush, backpressure and reset.
module tb_mdu_iter;

`ifdef MDU_FAST_PATH_EN
  localparam int SPEC64 = 1;
  localparam int SPEC32 = 1;
`else
  localparam int SPEC64 = 66;
  localparam int SPEC32 = 34;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_miscmp = 0;
  logic [63:0] exp_q[$];

  mdu_iter_if #(.XLEN(64)) bus ();

  mdu_iter #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic word, input logic [63:0] s1, input logic [63:0] s2);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.word     = word;
    bus.src1     = s1;
    bus.src2     = s2;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom_range(0, 7));
    bus.word     = 1'($urandom_range(0, 1));
    bus.src1     = {$urandom, $urandom};
    bus.src2     = {$urandom, $urandom};
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic take_result(input string tag);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    check(tag, bus.result, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] exp, input int exp_lat);
    exp_q.push_back(exp);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    start_op(op, word, s1, s2);
    wait_result(tag, exp_lat);
    take_result(tag);
  endtask

  initial begin
    logic [63:0] held;
    bit          seen;

    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.word      = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Clock/reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Main function
    run_op("mul",    3'b000, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    run_op("mulhu",  3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("mulh",   3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("mulhsu", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("mulw",   3'b000, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op("divw",   3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run_op("remw",   3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divu",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    run_op("remu",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    run_op("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("divuw",  3'b101, 1'b1, 64'h1234_5678_8000_0000, 64'h2, 64'h0000_0000_4000_0000, 34);

    // Special cases
    run_op("div0",   3'b100, 1'b0, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC64);
    run_op("rem0",   3'b110, 1'b0, 64'h1234, 64'h0, 64'h1234, SPEC64);
    run_op("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, SPEC64);
    run_op("removf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, SPEC64);
    run_op("mulz",   3'b000, 1'b0, 64'h0, 64'h5, 64'h0, SPEC64);
    run_op("divw0",  3'b100, 1'b1, 64'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC32);
    run_op("remuw0", 3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, SPEC32);
    run_op("divwovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, SPEC32);

    // Flush mid-divide
    start_op(3'b101, 1'b0, 64'd1000, 64'd3);
    for (int i = 1; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_out_valid", 64'(seen), 64'd0);
    run_op("after_flush", 3'b101, 1'b0, 64'd1000, 64'd3, 64'd333, 66);

    // Backpressure in DONE
    exp_q.push_back(64'd14);
    start_op(3'b101, 1'b0, 64'd100, 64'd7);
    wait_result("bp", 66);
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", bus.result, held);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    take_result("bp");
    run_op("after_bp", 3'b011, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 66);

    // Reset during CALC
    start_op(3'b000, 1'b0, 64'h7, 64'h3);
    for (int i = 0; i < 5; i++) tick();
    check("calc_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstc_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstc_busy", 64'(bus.busy), 64'd0);
    check("rstc_in_ready", 64'(bus.in_ready), 64'd1);
    check("rstc_result", bus.result, 64'd0);
    check("rstc_state", 64'(dbg_state), 64'd0);
    run_op("after_rst", 3'b000, 1'b0, 64'h7, 64'h3, 64'd21, 66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of instruction decode.
- Consumes decode's DivEn, DivSel (funct3) and Div32 qualifiers plus the Rs1/Rs2 operand values.
- Produces one XLEN result per accepted operation through a valid/ready handshake; the pipeline stalls on in_ready/out_valid.
- One iteration per cycle (shift-add multiply, restoring divide); no hardware multiplier.

Parameters:
- XLEN, 64, datapath width; word ops always use 32 bits.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operation request (decode DivEn qualified by stage valid)
- in_ready  output  1  unit can accept; high only in IDLE
- op  input  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- word  input  1  1 = *W variant (mulw/divw/divuw/remw/remuw)
- src1  input  XLEN  rs1 value
- src2  input  XLEN  rs2 value
- flush  input  1  kill in-flight op (branch redirect/trap)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  final result
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; out_valid=0, result=0, busy=0, in_ready=1; counter and internal registers cleared.
- States: IDLE, CALC, POST, DONE.
- IDLE -> CALC on in_valid&in_ready.
  - Operands, op and word are latched on the handshake edge; inputs are don't-care afterwards.
  - Magnitudes and result-sign flags are computed at this edge.
  - Iteration count N = 64 if word=0, else 32.
- CALC: one multiply or divide step per cycle; counter decrements; after N steps -> POST.
- POST (1 cycle): apply sign correction, select low/high product or quotient/remainder, sign-extend word results from bit 31 -> DONE.
- DONE: out_valid=1 and result held stable.
  - out_valid&out_ready -> IDLE.
  - Result stays stable while out_ready=0.
- Latency: handshake in cycle 0 -> out_valid first high in cycle N+2 (66 for 64-bit, 34 for word).
- in_ready=0 in DONE, so there is no back-to-back overlap; a new op is accepted the cycle after the result is consumed.
- Word operand prep:
  - mulw: src[31:0].
  - divw/remw: sign-extend src[31:0].
  - divuw/remuw: zero-extend src[31:0].
- Signedness:
  - mulh: both operands signed.
  - mulhsu: src1 signed, src2 unsigned.
  - mulhu: both unsigned.
  - div/rem: signed; remainder sign follows the dividend.
  - mul/mulw take the low half; the high half is ignored.
- Special cases (mandatory results):
  - Divisor 0: quotient = all ones (word: sign-extended 0xFFFFFFFF), remainder = dividend (word: sign-extended low 32).
  - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
- Word ops with op=001..011 are illegal; decode never issues them; result is unspecified but the FSM must still complete.
- flush: in any state, next state=IDLE and out_valid=0 next cycle; the result is discarded.
  - flush coincident with in_valid in IDLE: the request is dropped.
  - flush has priority over the out handshake.
- rst has priority over flush and over all handshakes.

Optional Feature:
- MDU_FAST_PATH_EN defined:
  - Divide-by-zero, signed overflow, and multiply with either (prepared) operand zero skip CALC/POST.
  - Handshake cycle 0 -> DONE -> out_valid in cycle 1.
- Undefined: these cases take the full N+2 latency.
- Result values are identical either way; only latency differs.

Test Plan:
- mul src1=0x7, src2=0xFFFFFFFFFFFFFFFD (word=0) -> result 0xFFFFFFFFFFFFFFEB; out_valid first in cycle 66.
- mulhu src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
- mulh src1=0x8000000000000000, src2=2 -> 0xFFFFFFFFFFFFFFFF.
- divw src1=0x00000000FFFFFFF9 (-7), src2=2 -> 0xFFFFFFFFFFFFFFFD; out_valid in cycle 34.
- remw, same operands -> 0xFFFFFFFFFFFFFFFF.
- div src2=0, src1=0x1234 -> 0xFFFFFFFFFFFFFFFF.
- rem src2=0, src1=0x1234 -> 0x1234.
- div src1=0x8000000000000000, src2=-1 -> 0x8000000000000000.
- Each special case: latency 1 cycle with MDU_FAST_PATH_EN, 66 cycles without.
- Start divu, assert flush in cycle 10 -> cycle 11: busy=0, in_ready=1, out_valid never rises; the next op completes correctly.
- Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0; op accepted in the cycle after out_ready=1 plus one.
- Assert rst during CALC -> next cycle all outputs at reset values.
